// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : MEM-stage load/store sequencer for a word-organised data memory
//            with a variable-latency ready handshake. Stalls the pipeline via
//            BUSYWAIT, builds store byte lanes and formats load data by FUNC3.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  input  logic [2:0]        FUNC3,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [31:0]       WRITE_DATA,
  output logic [31:0]       READ_DATA,
  output logic              BUSYWAIT,
  output logic              ACCESS_ERR,
  output logic              DM_READ,
  output logic              DM_WRITE,
  output logic [ADDR_W-3:0] DM_ADDR,
  output logic [31:0]       DM_WDATA,
  output logic [3:0]        DM_BYTE_EN,
  input  logic [31:0]       DM_RDATA,
  input  logic              DM_READY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] C_F3_B  = 3'b000;
  localparam logic [2:0] C_F3_H  = 3'b001;
  localparam logic [2:0] C_F3_W  = 3'b010;
  localparam logic [2:0] C_F3_BU = 3'b100;
  localparam logic [2:0] C_F3_HU = 3'b101;

  state_t            state_q;
  logic [2:0]        func3_q;
  logic [1:0]        offs_q;
  logic [31:0]       read_data_q;
  logic              access_err_q;
  logic              dm_read_q;
  logic              dm_write_q;
  logic [ADDR_W-3:0] dm_addr_q;
  logic [31:0]       dm_wdata_q;
  logic [3:0]        dm_be_q;

  logic              ld_legal;
  logic              st_legal;
  logic              req_any;
  logic              req_legal;
  logic [3:0]        st_be_d;
  logic [31:0]       st_wdata_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data_d;

  // Legality of the presented request: width code plus natural alignment
  always_comb begin
    ld_legal = 1'b0;
    st_legal = 1'b0;
    case (FUNC3)
      C_F3_B: begin
        ld_legal = 1'b1;
        st_legal = 1'b1;
      end
      C_F3_H: begin
        ld_legal = ~ADDRESS[0];
        st_legal = ~ADDRESS[0];
      end
      C_F3_W: begin
        ld_legal = (ADDRESS[1:0] == 2'b00);
        st_legal = (ADDRESS[1:0] == 2'b00);
      end
      C_F3_BU: ld_legal = 1'b1;
      C_F3_HU: ld_legal = ~ADDRESS[0];
      default: begin
        ld_legal = 1'b0;
        st_legal = 1'b0;
      end
    endcase
  end

  // A read takes priority, so a simultaneous write is judged by load rules
  assign req_any   = MEM_READ | MEM_WRITE;
  assign req_legal = MEM_READ ? ld_legal : (MEM_WRITE & st_legal);

  // Store byte lanes and lane-replicated write data
  always_comb begin
    st_be_d    = 4'b1111;
    st_wdata_d = WRITE_DATA;
    case (FUNC3[1:0])
      2'b00: begin
        st_be_d    = 4'b0001 << ADDRESS[1:0];
        st_wdata_d = {4{WRITE_DATA[7:0]}};
      end
      2'b01: begin
        st_be_d    = ADDRESS[1] ? 4'b1100 : 4'b0011;
        st_wdata_d = {2{WRITE_DATA[15:0]}};
      end
      default: begin
        st_be_d    = 4'b1111;
        st_wdata_d = WRITE_DATA;
      end
    endcase
  end

  // Load lane selection and sign/zero extension, using the width and offset
  // captured at issue so the pipeline inputs need not be trusted later
  always_comb begin
    case (offs_q)
      2'b00:   ld_byte = DM_RDATA[7:0];
      2'b01:   ld_byte = DM_RDATA[15:8];
      2'b10:   ld_byte = DM_RDATA[23:16];
      default: ld_byte = DM_RDATA[31:24];
    endcase
    ld_half = offs_q[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];
    case (func3_q)
      C_F3_B:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      C_F3_BU: ld_data_d = {24'd0, ld_byte};
      C_F3_H:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      C_F3_HU: ld_data_d = {16'd0, ld_half};
      default: ld_data_d = DM_RDATA;
    endcase
  end

  // Access sequencer with registered memory-side and result outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      func3_q      <= 3'd0;
      offs_q       <= 2'd0;
      read_data_q  <= 32'd0;
      access_err_q <= 1'b0;
      dm_read_q    <= 1'b0;
      dm_write_q   <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= 32'd0;
      dm_be_q      <= 4'd0;
    end else begin
      access_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_any && req_legal) begin
            dm_addr_q <= ADDRESS[ADDR_W-1:2];
            func3_q   <= FUNC3;
            offs_q    <= ADDRESS[1:0];
            if (MEM_READ) begin
              dm_read_q <= 1'b1;
              dm_be_q   <= 4'd0;
              state_q   <= ST_READ;
            end else begin
              dm_write_q <= 1'b1;
              dm_be_q    <= st_be_d;
              dm_wdata_q <= st_wdata_d;
              state_q    <= ST_WRITE;
            end
          end else if (req_any) begin
            // Rejected access: flag it, never touch memory, stay idle
            access_err_q <= 1'b1;
            if (MEM_READ) begin
              read_data_q <= 32'd0;
            end
          end
        end
        ST_READ: begin
          if (DM_READY) begin
            dm_read_q   <= 1'b0;
            read_data_q <= ld_data_d;
            state_q     <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (DM_READY) begin
            dm_write_q <= 1'b0;
            state_q    <= ST_DONE;
          end
        end
        // The still-held request is consumed here and not re-issued
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall from the first request cycle until memory completion
  assign BUSYWAIT = ~RESET & (((state_q == ST_IDLE) & req_any & req_legal) |
                              (state_q == ST_READ) | (state_q == ST_WRITE));

  assign READ_DATA  = read_data_q;
  assign ACCESS_ERR = access_err_q;
  assign DM_READ    = dm_read_q;
  assign DM_WRITE   = dm_write_q;
  assign DM_ADDR    = dm_addr_q;
  assign DM_WDATA   = dm_wdata_q;
  assign DM_BYTE_EN = dm_be_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Self-checking bench for data_mem_ctrl. A driver issues directed
//            and random loads/stores against a byte-level memory model and
//            queues expected responses; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int          kind;
    bit [29:0]   waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy;
    int          strobes;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        ACCESS_ERR;
  logic        DM_READ;
  logic        DM_WRITE;
  logic [29:0] DM_ADDR;
  logic [31:0] DM_WDATA;
  logic [3:0]  DM_BYTE_EN;
  logic [31:0] DM_RDATA;
  logic        DM_READY;

  exp_t        sbq[$];
  logic [31:0] mem [bit [29:0]];
  logic [31:0] model_rd;
  int          n_checks;
  int          n_fail;

  data_mem_ctrl #(.ADDR_W(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .FUNC3      (FUNC3),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT),
    .ACCESS_ERR (ACCESS_ERR),
    .DM_READ    (DM_READ),
    .DM_WRITE   (DM_WRITE),
    .DM_ADDR    (DM_ADDR),
    .DM_WDATA   (DM_WDATA),
    .DM_BYTE_EN (DM_BYTE_EN),
    .DM_RDATA   (DM_RDATA),
    .DM_READY   (DM_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  // Architectural load result: pick the addressed byte/half and extend it
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] word,
                                             input int off);
    longint b, h, v;
    b = longint'((word >> (8 * off)) % 256);
    h = longint'((word >> (16 * (off / 2))) % 65536);
    case (f3)
      3'd0:    v = (b >= 128) ? b - 256 : b;
      3'd4:    v = b;
      3'd1:    v = (h >= 32768) ? h - 65536 : h;
      3'd5:    v = h;
      default: v = longint'(word);
    endcase
    return 32'(v);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_read_data"}, READ_DATA, 32'd0);
    chk({tag, "_busywait"}, 32'(BUSYWAIT), 32'd0);
    chk({tag, "_access_err"}, 32'(ACCESS_ERR), 32'd0);
    chk({tag, "_dm_read"}, 32'(DM_READ), 32'd0);
    chk({tag, "_dm_write"}, 32'(DM_WRITE), 32'd0);
    chk({tag, "_dm_addr"}, 32'(DM_ADDR), 32'd0);
    chk({tag, "_dm_wdata"}, DM_WDATA, 32'd0);
    chk({tag, "_dm_byte_en"}, 32'(DM_BYTE_EN), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      DM_READY  = 1'($urandom_range(0, 1));
      DM_RDATA  = $urandom;
      @(posedge CLK);
      #1;
    end
  endtask

  // Issue one request (called 1 ns after a rising edge) and play the memory
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int delay);
    exp_t        e;
    bit          legal;
    int          size;
    int          off;
    bit [29:0]   w;
    logic [31:0] word;
    logic [31:0] mask;
    w    = addr[31:2];
    off  = int'(addr % 4);
    size = int'(f3 % 4);
    if (!mem.exists(w)) mem[w] = $urandom;
    word = mem[w];
    if (rd) legal = (size != 3) && !(f3 >= 4 && size == 2) && (addr % (1 << size) == 0);
    else    legal = (f3 < 3) && (addr % (1 << size) == 0);
    e.waddr   = w;
    e.be      = 4'd0;
    e.wdata   = 32'd0;
    e.busy    = legal ? delay + 1 : 0;
    e.strobes = legal ? delay : 0;
    if (!legal) begin
      e.kind = K_ERR;
      if (rd) model_rd = 32'd0;
    end else if (rd) begin
      e.kind   = K_LOAD;
      model_rd = model_load(f3, word, off);
    end else begin
      e.kind = K_STORE;
      case (size)
        0: begin
          e.be    = 4'(1 << off);
          e.wdata = (wd % 256) * 32'h0101_0101;
        end
        1: begin
          e.be    = (off >= 2) ? 4'b1100 : 4'b0011;
          e.wdata = (wd % 65536) * 32'h0001_0001;
        end
        default: begin
          e.be    = 4'b1111;
          e.wdata = wd;
        end
      endcase
      mask = 32'd0;
      for (int n = 0; n < 4; n++) if (e.be[n]) mask = mask | (32'hFF << (8 * n));
      mem[w] = (word & ~mask) | (e.wdata & mask);
    end
    e.rdata = model_rd;
    sbq.push_back(e);

    MEM_READ   = rd;
    MEM_WRITE  = wr;
    FUNC3      = f3;
    ADDRESS    = addr;
    WRITE_DATA = wd;
    DM_READY   = 1'($urandom_range(0, 1));
    DM_RDATA   = $urandom;
    if (legal) begin
      for (int c = 1; c <= delay; c++) begin
        @(posedge CLK);
        #1;
        DM_READY = (c == delay);
        DM_RDATA = (c == delay) ? word : $urandom;
      end
      // Completion cycle: request still held, stray ready must be ignored
      @(posedge CLK);
      #1;
      DM_READY = 1'($urandom_range(0, 1));
      DM_RDATA = $urandom;
    end
    @(posedge CLK);
    #1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    DM_READY  = 1'($urandom_range(0, 1));
  endtask

  // Monitor: compares memory-side strobes, completions and error pulses
  initial begin : p_monitor
    bit   prev_strobe;
    bit   strobe;
    int   busy_cnt;
    int   strobe_cnt;
    exp_t cur;
    prev_strobe = 1'b0;
    busy_cnt    = 0;
    strobe_cnt  = 0;
    forever begin
      @(negedge CLK);
      strobe = (DM_READ === 1'b1) || (DM_WRITE === 1'b1);
      if (!strobe && prev_strobe) begin
        if (sbq.size() == 0) fail_now("unexpected_completion");
        else begin
          cur = sbq.pop_front();
          chk("read_data", READ_DATA, cur.rdata);
          chk("busy_cycles", busy_cnt, cur.busy);
          chk("strobe_cycles", strobe_cnt, cur.strobes);
        end
        busy_cnt   = 0;
        strobe_cnt = 0;
      end
      if (ACCESS_ERR === 1'b1) begin
        if (sbq.size() == 0) fail_now("unexpected_access_err");
        else begin
          cur = sbq.pop_front();
          chk("err_expected", 32'(cur.kind), K_ERR);
          chk("err_read_data", READ_DATA, cur.rdata);
          chk("err_busy_cycles", busy_cnt, cur.busy);
          chk("err_strobe_cycles", strobe_cnt, cur.strobes);
        end
        busy_cnt   = 0;
        strobe_cnt = 0;
      end
      if (BUSYWAIT === 1'b1) busy_cnt++;
      if (strobe) begin
        strobe_cnt++;
        if (sbq.size() == 0) begin
          if (!prev_strobe) fail_now("unexpected_strobe");
        end else begin
          cur = sbq[0];
          chk("dm_read", 32'(DM_READ), 32'(cur.kind == K_LOAD));
          chk("dm_write", 32'(DM_WRITE), 32'(cur.kind == K_STORE));
          chk("dm_addr", 32'(DM_ADDR), 32'(cur.waddr));
          if (cur.kind == K_STORE) begin
            chk("dm_byte_en", 32'(DM_BYTE_EN), 32'(cur.be));
            chk("dm_wdata", DM_WDATA, cur.wdata);
          end
        end
      end
      prev_strobe = strobe;
    end
  end

  // Driver: reset, directed scenarios, then randomized traffic
  initial begin : p_driver
    exp_t ab;
    bit   r_rd;
    bit   r_wr;
    n_checks   = 0;
    n_fail     = 0;
    model_rd   = 32'd0;
    RESET      = 1'b1;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    FUNC3      = 3'd0;
    ADDRESS    = 32'd0;
    WRITE_DATA = 32'd0;
    DM_RDATA   = 32'd0;
    DM_READY   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    MEM_READ = 1'b1;
    FUNC3    = 3'b010;
    ADDRESS  = 32'h100;
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK);
    #1;
    RESET    = 1'b0;
    MEM_READ = 1'b0;

    mem[30'h40] = 32'h0000_CC66;
    access(1, 0, 3'b000, 32'h101, 32'd0, 1);   // LB  -> FFFFFFCC
    access(1, 0, 3'b100, 32'h101, 32'd0, 1);   // LBU -> 000000CC
    access(1, 0, 3'b101, 32'h100, 32'd0, 2);   // LHU -> 0000CC66
    access(1, 0, 3'b001, 32'h100, 32'd0, 1);   // LH  -> FFFFCC66
    access(1, 0, 3'b010, 32'h100, 32'd0, 3);   // LW  -> 0000CC66
    access(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 4);  // SB, slow memory
    access(0, 1, 3'b001, 32'h201, 32'h1234_5678, 1);  // misaligned SH
    access(1, 0, 3'b010, 32'h102, 32'd0, 1);          // misaligned LW
    access(1, 1, 3'b010, 32'h100, 32'hFFFF_FFFF, 2);  // read wins
    access(1, 0, 3'b011, 32'h100, 32'd0, 1);          // illegal load code
    access(0, 1, 3'b011, 32'h100, 32'd0, 1);          // illegal store code
    access(0, 1, 3'b001, 32'h102, 32'hABCD_BEEF, 1);  // SH upper half
    access(1, 0, 3'b001, 32'h102, 32'd0, 1);          // LH of it
    idle(1);

    // Reset while a load waits on memory: access abandoned, nothing written
    ab.kind    = K_LOAD;
    ab.waddr   = 30'h40;
    ab.be      = 4'd0;
    ab.wdata   = 32'd0;
    ab.rdata   = 32'd0;
    ab.busy    = 2;
    ab.strobes = 2;
    sbq.push_back(ab);
    MEM_READ  = 1'b1;
    MEM_WRITE = 1'b0;
    FUNC3     = 3'b010;
    ADDRESS   = 32'h100;
    DM_READY  = 1'b0;
    @(posedge CLK);
    #1;
    DM_READY = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET    = 1'b0;
    MEM_READ = 1'b0;
    model_rd = 32'd0;
    @(negedge CLK);
    check_all_zero("mid_reset");
    @(posedge CLK);
    #1;
    DM_READY = 1'b1;
    DM_RDATA = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    DM_READY = 1'b0;
    @(negedge CLK);
    chk("stray_ready_dm_read", 32'(DM_READ), 32'd0);
    chk("stray_ready_read_data", READ_DATA, 32'd0);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 300; i++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_wr = r_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      access(r_rd, r_wr, 3'($urandom_range(0, 7)),
             32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
             $urandom, int'($urandom_range(1, 5)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
